// File: rtl/qcost_pkg.sv
// Shared types, width helpers and output saturation for the quadratic cost evaluator.
package qcost_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_SQ   = 3'd1,
      ST_MAC  = 3'd2,
      ST_BIAS = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   typedef struct packed {
      logic               ovf;
      logic signed [63:0] val;
   } sat_t;

   function automatic int diff_w(input int in_w);
      return in_w + 1;
   endfunction

   function automatic int sq_w(input int in_w, input int frac);
      return 2 * (in_w + 1) - frac;
   endfunction

   // Sized so the N-term sum of weighted squares can never wrap.
   function automatic int acc_w(input int in_w, input int frac, input int n_dim);
      return 3 * in_w + 3 - 2 * frac + $clog2(n_dim);
   endfunction

   function automatic sat_t saturate(input logic signed [63:0] v, input int unsigned w);
      sat_t               r;
      logic signed [63:0] mx;
      logic signed [63:0] mn;
      mx    = (64'sd1 <<< (w - 1)) - 64'sd1;
      mn    = -mx - 64'sd1;
      r.ovf = 1'b0;
      r.val = v;
      if (v > mx) begin
         r.ovf = 1'b1;
         r.val = mx;
      end else if (v < mn) begin
         r.ovf = 1'b1;
         r.val = mn;
      end
      return r;
   endfunction

endpackage

// File: rtl/fixed_mult_param.sv
// Signed A_W x B_W multiplier; full-width product floored by FRAC bits.
module fixed_mult_param #(
   parameter int A_W  = 17,
   parameter int B_W  = 26,
   parameter int FRAC = 8
) (
   input  logic signed [A_W-1:0]     a_i,
   input  logic signed [B_W-1:0]     b_i,
   output logic signed [A_W+B_W-1:0] p_o
);

   logic signed [A_W+B_W-1:0] full;

   assign full = a_i * b_i;
   assign p_o  = full >>> FRAC;

endmodule

// File: rtl/quad_cost_eval.sv
// z = sum_i w_i*(x_i-o_i)^2 + bias, evaluated on one shared multiplier, saturated to OUT_W.
module quad_cost_eval
   import qcost_pkg::*;
#(
   parameter int N_DIM = 4,
   parameter int IN_W  = 16,
   parameter int FRAC  = 8,
   parameter int OUT_W = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start_func,
   input  logic [N_DIM*IN_W-1:0]   x_in,
   input  logic [N_DIM*IN_W-1:0]   off_in,
   input  logic [N_DIM*IN_W-1:0]   wt_in,
   input  logic [OUT_W-1:0]        bias_in,
   output logic [OUT_W-1:0]        z_out,
   output logic                    func_done,
   output logic                    overflow,
   output logic                    busy
);

   localparam int DIFF_W = diff_w(IN_W);
   localparam int SQ_W   = sq_w(IN_W, FRAC);
   localparam int ACC_W  = acc_w(IN_W, FRAC, N_DIM);
   localparam int PROD_W = DIFF_W + SQ_W;
   localparam int K_W    = (N_DIM > 1) ? $clog2(N_DIM) : 1;

   state_t                   state_q, state_d;
   logic [K_W-1:0]           k_q, k_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic [OUT_W-1:0]         z_q, z_d;
   logic                     done_q, done_d;
   logic                     ovf_q, ovf_d;
   logic                     busy_q, busy_d;
   logic                     capture;

   logic [N_DIM*IN_W-1:0]    x_q, off_q, wt_q;
   logic signed [OUT_W-1:0]  bias_q;
   logic signed [SQ_W-1:0]   sq_q;

   logic signed [IN_W-1:0]   x_k, o_k, w_k;
   logic signed [DIFF_W-1:0] diff;
   logic signed [DIFF_W-1:0] mult_a;
   logic signed [SQ_W-1:0]   mult_b;
   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  mac_term;
   logic signed [ACC_W:0]    sum;
   logic signed [63:0]       sum64;
   sat_t                     sat_r;
   logic                     unused_bits;

   assign x_k  = x_q[int'(k_q)*IN_W +: IN_W];
   assign o_k  = off_q[int'(k_q)*IN_W +: IN_W];
   assign w_k  = wt_q[int'(k_q)*IN_W +: IN_W];
   assign diff = {x_k[IN_W-1], x_k} - {o_k[IN_W-1], o_k};

   // Operand mux: (d,d) while squaring, (w_k,sq) while accumulating.
   assign mult_a = (state_q == ST_MAC) ? {w_k[IN_W-1], w_k} : diff;
   assign mult_b = (state_q == ST_MAC) ? sq_q
                                       : {{(SQ_W-DIFF_W){diff[DIFF_W-1]}}, diff};

   fixed_mult_param #(
      .A_W  (DIFF_W),
      .B_W  (SQ_W),
      .FRAC (FRAC)
   ) u_mult (
      .a_i (mult_a),
      .b_i (mult_b),
      .p_o (prod)
   );

   assign mac_term    = prod[ACC_W-1:0];
   assign sum         = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-OUT_W){bias_q[OUT_W-1]}}, bias_q};
   assign sum64       = {{(63-ACC_W){sum[ACC_W]}}, sum};
   assign sat_r       = saturate(sum64, OUT_W);
   assign unused_bits = ^{prod[PROD_W-1:ACC_W], sat_r.val[63:OUT_W]};

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      acc_d   = acc_q;
      z_d     = z_q;
      done_d  = done_q;
      ovf_d   = ovf_q;
      busy_d  = busy_q;
      capture = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_func) begin
               capture = 1'b1;
               acc_d   = '0;
               ovf_d   = 1'b0;
               busy_d  = 1'b1;
               k_d     = '0;
               state_d = ST_SQ;
            end
         end
         ST_SQ: state_d = ST_MAC;
         ST_MAC: begin
            acc_d = acc_q + mac_term;
            if (k_q == K_W'(N_DIM - 1)) begin
               state_d = ST_BIAS;
            end else begin
               k_d     = k_q + K_W'(1);
               state_d = ST_SQ;
            end
         end
         ST_BIAS: begin
            z_d     = sat_r.val[OUT_W-1:0];
            ovf_d   = sat_r.ovf;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            // Hold the result until the requester drops start_func.
            if (!start_func) begin
               done_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         k_q     <= '0;
         acc_q   <= '0;
         z_q     <= '0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         acc_q   <= acc_d;
         z_q     <= z_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
      end
   end

   // Operand buffers are always rewritten on capture, so they carry no reset.
   always_ff @(posedge clk) begin
      if (capture) begin
         x_q    <= x_in;
         off_q  <= off_in;
         wt_q   <= wt_in;
         bias_q <= bias_in;
      end
      if (state_q == ST_SQ) begin
         sq_q <= prod[SQ_W-1:0];
      end
   end

   assign z_out     = z_q;
   assign func_done = done_q;
   assign overflow  = ovf_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_quad_cost_eval.sv
// Scoreboard bench for quad_cost_eval (N_DIM=4, IN_W=16, FRAC=8, OUT_W=32).
module tb_quad_cost_eval;

   localparam int N_DIM = 4;
   localparam int IN_W  = 16;
   localparam int FRAC  = 8;
   localparam int OUT_W = 32;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic                  start_func = 1'b0;
   logic [N_DIM*IN_W-1:0] x_in = '0;
   logic [N_DIM*IN_W-1:0] off_in = '0;
   logic [N_DIM*IN_W-1:0] wt_in = '0;
   logic [OUT_W-1:0]      bias_in = '0;
   logic [OUT_W-1:0]      z_out;
   logic                  func_done;
   logic                  overflow;
   logic                  busy;

   quad_cost_eval #(
      .N_DIM (N_DIM),
      .IN_W  (IN_W),
      .FRAC  (FRAC),
      .OUT_W (OUT_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_func (start_func),
      .x_in       (x_in),
      .off_in     (off_in),
      .wt_in      (wt_in),
      .bias_in    (bias_in),
      .z_out      (z_out),
      .func_done  (func_done),
      .overflow   (overflow),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [OUT_W-1:0] z;
      logic             ovf;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] pack4(input logic [15:0] e0, input logic [15:0] e1,
                                         input logic [15:0] e2, input logic [15:0] e3);
      return {e3, e2, e1, e0};
   endfunction

   // Reference: floor-shifted fixed point in 64-bit integers, saturation at the end.
   function automatic exp_t model(input logic [63:0] x, input logic [63:0] off,
                                  input logic [63:0] wt, input logic [31:0] bias);
      exp_t   e;
      longint acc, d, sq, s, mx, mn;
      acc = 0;
      for (int i = 0; i < N_DIM; i++) begin
         d   = longint'($signed(x[i*IN_W +: IN_W])) - longint'($signed(off[i*IN_W +: IN_W]));
         sq  = (d * d) >>> FRAC;
         acc = acc + ((longint'($signed(wt[i*IN_W +: IN_W])) * sq) >>> FRAC);
      end
      s  = acc + longint'($signed(bias));
      mx = 64'sd2147483647;
      mn = -64'sd2147483648;
      e.ovf = 1'b0;
      if (s > mx) begin
         s = mx; e.ovf = 1'b1;
      end else if (s < mn) begin
         s = mn; e.ovf = 1'b1;
      end
      e.z = s[OUT_W-1:0];
      return e;
   endfunction

   task automatic run(input string tag, input logic [63:0] x, input logic [63:0] off,
                      input logic [63:0] wt, input logic [31:0] bias,
                      input logic [31:0] exp_z, input logic exp_ovf, input bit hold_long);
      exp_t e;
      exp_t m;
      int   cnt;
      m = model(x, off, wt, bias);
      check_eq({tag, "_model_z"}, {32'd0, m.z}, {32'd0, exp_z});
      e.z   = exp_z;
      e.ovf = exp_ovf;
      sb.push_back(e);
      @(negedge clk);
      x_in = x; off_in = off; wt_in = wt; bias_in = bias; start_func = 1'b1;
      @(posedge clk); #1;
      check_eq({tag, "_busy"}, {63'd0, busy}, 64'd1);
      @(negedge clk);
      x_in = {$urandom, $urandom}; off_in = {$urandom, $urandom};
      wt_in = {$urandom, $urandom}; bias_in = $urandom;
      cnt = 1;
      @(posedge clk); #1;
      while (!func_done && cnt < 50) begin
         @(posedge clk); #1;
         cnt++;
      end
      check_eq({tag, "_latency"}, 64'(cnt), 64'd9);
      e = sb.pop_front();
      check_eq({tag, "_z"}, {32'd0, z_out}, {32'd0, e.z});
      check_eq({tag, "_ovf"}, {63'd0, overflow}, {63'd0, e.ovf});
      check_eq({tag, "_busy_end"}, {63'd0, busy}, 64'd0);
      if (hold_long) begin
         repeat (20) @(posedge clk);
         #1;
         check_eq({tag, "_hold_done"}, {63'd0, func_done}, 64'd1);
         check_eq({tag, "_hold_busy"}, {63'd0, busy}, 64'd0);
         check_eq({tag, "_hold_z"}, {32'd0, z_out}, {32'd0, e.z});
      end
      @(negedge clk);
      start_func = 1'b0;
      @(posedge clk); #1;
      check_eq({tag, "_done_clr"}, {63'd0, func_done}, 64'd0);
      check_eq({tag, "_z_held"}, {32'd0, z_out}, {32'd0, e.z});
   endtask

   logic [63:0] wt_c, off_c, x_r, o_r, w_r;
   logic [31:0] b_c, b_r;
   exp_t        rnd_e;

   initial begin
      wt_c  = pack4(16'h0100, 16'h0100, 16'h0100, 16'h1900);
      off_c = pack4(16'h0200, 16'h0000, 16'hFE00, 16'h0000);
      b_c   = 32'hFFFFFB00;

      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_z", {32'd0, z_out}, 64'd0);
      check_eq("rst_ctrl", {61'd0, func_done, overflow, busy}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run("min", pack4(16'h0200, 16'h0000, 16'hFE00, 16'h0000), off_c, wt_c, b_c,
          32'hFFFFFB00, 1'b0, 1'b0);
      run("int", pack4(16'h0300, 16'h0100, 16'hFF00, 16'h0100), off_c, wt_c, b_c,
          32'h00001700, 1'b0, 1'b0);
      run("frac", pack4(16'h0080, 16'h0000, 16'hFE00, 16'h0000), off_c, wt_c, b_c,
          32'hFFFFFD40, 1'b0, 1'b0);
      run("sat_hi", {4{16'h7FFF}}, {4{16'h8000}}, {4{16'h7FFF}}, 32'd0,
          32'h7FFFFFFF, 1'b1, 1'b0);
      run("sat_lo", {4{16'h7FFF}}, {4{16'h8000}}, {4{16'h8000}}, 32'd0,
          32'h80000000, 1'b1, 1'b0);
      run("hold", pack4(16'h0200, 16'h0000, 16'hFE00, 16'h0000), off_c, wt_c, b_c,
          32'hFFFFFB00, 1'b0, 1'b1);
      run("rearm", pack4(16'h0300, 16'h0100, 16'hFF00, 16'h0100), off_c, wt_c, b_c,
          32'h00001700, 1'b0, 1'b0);

      for (int r = 0; r < 4; r++) begin
         x_r = {$urandom, $urandom}; o_r = {$urandom, $urandom};
         w_r = {$urandom, $urandom}; b_r = $urandom;
         rnd_e = model(x_r, o_r, w_r, b_r);
         run($sformatf("rnd%0d", r), x_r, o_r, w_r, b_r, rnd_e.z, rnd_e.ovf, 1'b0);
      end

      // Abort a run three cycles after capture with an asynchronous reset.
      @(negedge clk);
      x_in = pack4(16'h0300, 16'h0100, 16'hFF00, 16'h0100);
      off_in = off_c; wt_in = wt_c; bias_in = b_c; start_func = 1'b1;
      @(posedge clk);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("abort_z", {32'd0, z_out}, 64'd0);
      check_eq("abort_ctrl", {61'd0, func_done, overflow, busy}, 64'd0);
      start_func = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      run("post_rst", pack4(16'h0200, 16'h0000, 16'hFE00, 16'h0000), off_c, wt_c, b_c,
          32'hFFFFFB00, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
